iod_eye_center_train: RTL and testbench

IOD_EYE_CENTER_TRAIN -- requirements
Module: iod_eye_center_train

---
 rtl/iod_eye_center_train.sv | 244 ++++++++++++++++++++++++
 tb/tb_iod_eye_center_train.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iod_eye_center_train.sv
// ============================================================================
//  Module   : iod_eye_center_train
//  Purpose  : Per-bit IOD delay-line sweep that finds the widest passing eye
//             window and parks each lane at the centre tap of that window.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iod_eye_center_train #(
    parameter int NUM_BITS      = 8,
    parameter int TAP_W         = 7,
    parameter int MAX_TAP       = 127,
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLE_CYCLES = 16
) (
    input  logic                FAB_CLK,
    input  logic                SYNC_RST,
    input  logic                START,
    output logic                BUSY,
    output logic                DONE,
    output logic [NUM_BITS-1:0] ERR,
    output logic [NUM_BITS-1:0] DELAY_LINE_MOVE,
    output logic [NUM_BITS-1:0] DELAY_LINE_DIRECTION,
    output logic [NUM_BITS-1:0] DELAY_LINE_LOAD,
    output logic [NUM_BITS-1:0] EYE_MONITOR_CLEAR_FLAGS,
    input  logic [NUM_BITS-1:0] EYE_MONITOR_EARLY,
    input  logic [NUM_BITS-1:0] EYE_MONITOR_LATE,
    input  logic [NUM_BITS-1:0] DELAY_LINE_OUT_OF_RANGE,
    input  logic [((NUM_BITS > 1) ? $clog2(NUM_BITS) : 1)-1:0] TAP_RD_SEL,
    output logic [TAP_W-1:0]    TAP_RD_DATA
);

    localparam int c_SEL_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int c_CNT_W = 16;

    localparam logic [c_SEL_W-1:0] c_LAST_BIT     = c_SEL_W'(NUM_BITS - 1);
    localparam logic [TAP_W-1:0]   c_MAX_TAP      = TAP_W'(MAX_TAP);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST  = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SAMPLE_LAST  = c_CNT_W'(SAMPLE_CYCLES - 1);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_LOAD   = 4'd1;
    localparam logic [3:0] S_SETTLE = 4'd2;
    localparam logic [3:0] S_CLEAR  = 4'd3;
    localparam logic [3:0] S_SAMPLE = 4'd4;
    localparam logic [3:0] S_EVAL   = 4'd5;
    localparam logic [3:0] S_STEP   = 4'd6;
    localparam logic [3:0] S_RETURN = 4'd7;
    localparam logic [3:0] S_NEXT   = 4'd8;
    localparam logic [3:0] S_FINISH = 4'd9;

    logic [3:0]          r_state;
    logic [3:0]          w_next;
    logic [c_SEL_W-1:0]  r_bit;
    logic [TAP_W-1:0]    r_tap;
    logic [TAP_W-1:0]    r_run_start;
    logic [TAP_W-1:0]    r_best_start;
    logic [TAP_W:0]      r_run_len;
    logic [TAP_W:0]      r_best_len;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_fail;
    logic                r_returning;
    logic                r_dir_ready;
    logic [NUM_BITS-1:0] r_dir;
    logic [NUM_BITS-1:0] r_err;
    logic [TAP_W-1:0]    r_results [NUM_BITS];

    logic [NUM_BITS-1:0] w_onehot;
    logic [NUM_BITS-1:0] w_move;
    logic [NUM_BITS-1:0] w_load;
    logic [NUM_BITS-1:0] w_clear;
    logic                w_bit_fail;
    logic                w_settle_done;
    logic                w_sample_done;
    logic                w_sweep_end;
    logic                w_have_eye;
    logic                w_ret_down;
    logic [TAP_W:0]      w_run_len_inc;
    logic [TAP_W:0]      w_best_len_m1;
    logic [TAP_W:0]      w_centre;

    assign w_onehot      = NUM_BITS'(1) << r_bit;
    assign w_bit_fail    = EYE_MONITOR_EARLY[r_bit] | EYE_MONITOR_LATE[r_bit];
    assign w_settle_done = (r_cnt == c_SETTLE_LAST);
    assign w_sample_done = (r_cnt == c_SAMPLE_LAST);
    assign w_sweep_end   = (r_tap == c_MAX_TAP) || DELAY_LINE_OUT_OF_RANGE[r_bit];
    assign w_run_len_inc = r_run_len + 1'b1;
    assign w_have_eye    = (r_best_len != '0);
    assign w_best_len_m1 = r_best_len - 1'b1;
    // Centre is kept one bit wider so it can be compared against the tap directly.
    assign w_centre      = {1'b0, r_best_start} + (w_best_len_m1 >> 1);
    assign w_ret_down    = ({1'b0, r_tap} > w_centre);

    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_move  = '0;
        w_load  = '0;
        w_clear = '0;
        case (r_state)
            S_IDLE:   if (START) w_next = S_LOAD;
            S_LOAD: begin
                w_load = w_onehot;
                w_next = S_SETTLE;
            end
            S_SETTLE: if (w_settle_done) w_next = r_returning ? S_RETURN : S_CLEAR;
            S_CLEAR: begin
                w_clear = w_onehot;
                w_next  = S_SAMPLE;
            end
            S_SAMPLE: if (w_sample_done) w_next = S_EVAL;
            S_EVAL:   w_next = w_sweep_end ? S_RETURN : S_STEP;
            S_STEP: begin
                w_move = w_onehot;
                w_next = S_SETTLE;
            end
            S_RETURN: begin
                if (!w_have_eye) begin
                    w_load = w_onehot;
                    w_next = S_NEXT;
                end else if (w_ret_down) begin
                    // First RETURN cycle only lets the down direction settle.
                    if (r_dir_ready) begin
                        w_move = w_onehot;
                        w_next = S_SETTLE;
                    end
                end else begin
                    w_next = S_NEXT;
                end
            end
            S_NEXT:   w_next = (r_bit == c_LAST_BIT) ? S_FINISH : S_LOAD;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            r_bit        <= '0;
            r_tap        <= '0;
            r_run_start  <= '0;
            r_best_start <= '0;
            r_run_len    <= '0;
            r_best_len   <= '0;
            r_cnt        <= '0;
            r_fail       <= 1'b0;
            r_returning  <= 1'b0;
            r_dir_ready  <= 1'b0;
            r_dir        <= '0;
            r_err        <= '0;
            for (int i = 0; i < NUM_BITS; i++) begin
                r_results[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_err <= '0;
                        r_bit <= '0;
                    end
                end
                S_LOAD: begin
                    r_tap        <= '0;
                    r_run_start  <= '0;
                    r_best_start <= '0;
                    r_run_len    <= '0;
                    r_best_len   <= '0;
                    r_cnt        <= '0;
                    r_returning  <= 1'b0;
                    r_dir_ready  <= 1'b0;
                    r_dir        <= w_onehot;
                end
                S_SETTLE: r_cnt <= w_settle_done ? '0 : r_cnt + 1'b1;
                S_CLEAR: begin
                    r_fail <= 1'b0;
                    r_cnt  <= '0;
                end
                S_SAMPLE: begin
                    r_fail <= r_fail | w_bit_fail;
                    r_cnt  <= w_sample_done ? '0 : r_cnt + 1'b1;
                end
                S_EVAL: begin
                    if (!r_fail) begin
                        if (r_run_len == '0) r_run_start <= r_tap;
                        r_run_len <= w_run_len_inc;
                        // Strictly greater keeps the earliest of equal-width windows.
                        if (w_run_len_inc > r_best_len) begin
                            r_best_len   <= w_run_len_inc;
                            r_best_start <= (r_run_len == '0) ? r_tap : r_run_start;
                        end
                    end else begin
                        r_run_len <= '0;
                    end
                    if (w_sweep_end) begin
                        r_returning <= 1'b1;
                        r_dir       <= '0;
                    end
                end
                S_STEP: r_tap <= r_tap + 1'b1;
                S_RETURN: begin
                    r_dir_ready <= 1'b1;
                    if (!w_have_eye) begin
                        r_err[r_bit] <= 1'b1;
                        r_tap        <= '0;
                    end else if (w_ret_down && r_dir_ready) begin
                        r_tap <= r_tap - 1'b1;
                    end
                end
                S_NEXT: begin
                    r_results[r_bit] <= r_tap;
                    r_dir            <= '0;
                    r_returning      <= 1'b0;
                    if (r_bit != c_LAST_BIT) r_bit <= r_bit + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        TAP_RD_DATA = '0;
        for (int i = 0; i < NUM_BITS; i++) begin
            if (TAP_RD_SEL == c_SEL_W'(i)) TAP_RD_DATA = r_results[i];
        end
    end

    assign BUSY                    = (r_state != S_IDLE) && (r_state != S_FINISH);
    assign DONE                    = (r_state == S_FINISH);
    assign ERR                     = r_err;
    assign DELAY_LINE_MOVE         = w_move;
    assign DELAY_LINE_DIRECTION    = r_dir;
    assign DELAY_LINE_LOAD         = w_load;
    assign EYE_MONITOR_CLEAR_FLAGS = w_clear;

endmodule

`default_nettype wire

// File: tb/tb_iod_eye_center_train.sv
// ============================================================================
//  Module   : tb_iod_eye_center_train
//  Purpose  : Self-checking bench with a simple IOD tap/eye model for
//             iod_eye_center_train (2 lanes, 16 taps).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iod_eye_center_train;

    localparam int NB = 2;
    localparam int TW = 4;
    localparam int MT = 15;

    logic          FAB_CLK = 1'b0;
    logic          SYNC_RST;
    logic          START;
    logic          BUSY;
    logic          DONE;
    logic [NB-1:0] ERR;
    logic [NB-1:0] MOVE;
    logic [NB-1:0] DIR;
    logic [NB-1:0] LOAD;
    logic [NB-1:0] CLEAR;
    logic [NB-1:0] EARLY;
    logic [NB-1:0] LATE;
    logic [NB-1:0] OOR;
    logic          TAP_RD_SEL;
    logic [TW-1:0] TAP_RD_DATA;

    always #5 FAB_CLK = ~FAB_CLK;

    iod_eye_center_train #(
        .NUM_BITS(NB), .TAP_W(TW), .MAX_TAP(MT), .SETTLE_CYCLES(2), .SAMPLE_CYCLES(4)
    ) dut (
        .FAB_CLK(FAB_CLK), .SYNC_RST(SYNC_RST), .START(START), .BUSY(BUSY), .DONE(DONE),
        .ERR(ERR), .DELAY_LINE_MOVE(MOVE), .DELAY_LINE_DIRECTION(DIR),
        .DELAY_LINE_LOAD(LOAD), .EYE_MONITOR_CLEAR_FLAGS(CLEAR),
        .EYE_MONITOR_EARLY(EARLY), .EYE_MONITOR_LATE(LATE),
        .DELAY_LINE_OUT_OF_RANGE(OOR), .TAP_RD_SEL(TAP_RD_SEL), .TAP_RD_DATA(TAP_RD_DATA)
    );

    // IOD model: each lane has a tap position and a pass mask over taps.
    logic [15:0] mask    [NB];
    bit          oor_en  [NB];
    int          oor_tap [NB];
    int          mtap    [NB] = '{0, 0};

    always_comb begin
        EARLY = '0;
        LATE  = '0;
        OOR   = '0;
        for (int b = 0; b < NB; b++) begin
            if (!mask[b][mtap[b]]) begin
                if (mtap[b][0]) EARLY[b] = 1'b1;
                else            LATE[b]  = 1'b1;
            end
            if (oor_en[b] && mtap[b] >= oor_tap[b]) OOR[b] = 1'b1;
        end
    end

    int up_cnt [NB];
    int dn_cnt [NB];
    int ld_cnt [NB];
    int done_cnt, done_busy_bad, viol;
    logic [NB-1:0] dir_prev = '0;

    always @(negedge FAB_CLK) begin
        for (int b = 0; b < NB; b++) begin
            if (MOVE[b]) begin
                if (DIR[b] !== dir_prev[b] || LOAD[b]) viol++;
                if (DIR[b]) begin
                    up_cnt[b]++;
                    if (mtap[b] < MT) mtap[b]++;
                end else begin
                    dn_cnt[b]++;
                    if (mtap[b] > 0) mtap[b]--;
                end
            end
            if (LOAD[b]) begin
                ld_cnt[b]++;
                mtap[b] = 0;
            end
        end
        if ($countones(MOVE) > 1 || $countones(LOAD) > 1 || $countones(CLEAR) > 1) viol++;
        if (DONE) begin
            done_cnt++;
            if (BUSY) done_busy_bad++;
        end
        dir_prev = DIR;
    end

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Reference: sweep from tap 0 to the last reachable tap, pick the first longest window.
    function automatic void ref_bit(input logic [15:0] m, input bit oen, input int otap,
                                    output int up, output int dn, output int ld,
                                    output int res, output bit err);
        int last, bs, bl, l;
        last = MT;
        if (oen && otap < last) last = otap;
        bs = 0;
        bl = 0;
        for (int s = 0; s <= last; s++) begin
            if (m[s] && (s == 0 || !m[s-1])) begin
                l = 0;
                while (s + l <= last && m[s+l]) l++;
                if (l > bl) begin
                    bl = l;
                    bs = s;
                end
            end
        end
        err = (bl == 0);
        res = err ? 0 : bs + (bl - 1) / 2;
        up  = last;
        dn  = err ? 0 : last - res;
        ld  = err ? 2 : 1;
    endfunction

    task automatic read_res(input int b, output int v);
        TAP_RD_SEL = b[0];
        #1;
        v = int'(TAP_RD_DATA);
    endtask

    task automatic run_train(input bit poke);
        bit got;
        for (int b = 0; b < NB; b++) begin
            up_cnt[b] = 0;
            dn_cnt[b] = 0;
            ld_cnt[b] = 0;
        end
        done_cnt = 0;
        done_busy_bad = 0;
        viol = 0;
        @(posedge FAB_CLK); #1 START = 1'b1;
        @(posedge FAB_CLK); #1 START = 1'b0;
        @(negedge FAB_CLK);
        chk("busy_after_start", int'(BUSY), 1);
        got = 0;
        for (int c = 0; c < 4000 && !got; c++) begin
            @(posedge FAB_CLK); #1;
            START = poke && (c == 20 || c == 120 || c == 250);
            if (done_cnt > 0) got = 1;
        end
        START = 1'b0;
        chk("done_within_budget", int'(got), 1);
        repeat (3) @(posedge FAB_CLK);
        #1;
    endtask

    task automatic check_run(input string tag, input int r0, input int r1, input int err,
                             input int up0, input int dn0, input int ld0,
                             input int up1, input int dn1, input int ld1);
        int v;
        read_res(0, v); chk({tag, ".result0"}, v, r0);
        read_res(1, v); chk({tag, ".result1"}, v, r1);
        chk({tag, ".err"}, int'(ERR), err);
        chk({tag, ".up0"}, up_cnt[0], up0);
        chk({tag, ".down0"}, dn_cnt[0], dn0);
        chk({tag, ".load0"}, ld_cnt[0], ld0);
        chk({tag, ".up1"}, up_cnt[1], up1);
        chk({tag, ".down1"}, dn_cnt[1], dn1);
        chk({tag, ".load1"}, ld_cnt[1], ld1);
        chk({tag, ".done_pulses"}, done_cnt, 1);
        chk({tag, ".busy_during_done"}, done_busy_bad, 0);
        chk({tag, ".protocol"}, viol, 0);
        chk({tag, ".busy_after"}, int'(BUSY), 0);
    endtask

    typedef struct {
        logic [15:0] m0;
        logic [15:0] m1;
        bit          oen0;
        int          otap0;
        int          r0, r1, err;
        int          up0, dn0, ld0, up1, dn1;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int v;
        int up[NB], dn[NB], ld[NB], res[NB];
        bit er[NB];
        bit got;

        vecs[0] = '{16'h07F0, 16'h3F0F, 1'b0, 0,  7, 10, 0, 15, 8, 1, 15, 5};
        vecs[1] = '{16'h0000, 16'h3F0F, 1'b0, 0,  0, 10, 1, 15, 0, 2, 15, 5};
        vecs[2] = '{16'h1FF0, 16'h3F0F, 1'b1, 9,  6, 10, 0,  9, 3, 1, 15, 5};
        vecs[3] = '{16'hFFFF, 16'h8001, 1'b0, 0,  7,  0, 0, 15, 8, 1, 15, 15};

        mask[0] = '0; mask[1] = '0;
        oor_en[0] = 0; oor_en[1] = 0;
        oor_tap[0] = 0; oor_tap[1] = 0;
        SYNC_RST = 1'b1;
        START = 1'b0;
        TAP_RD_SEL = 1'b0;
        repeat (3) @(posedge FAB_CLK);
        #1 SYNC_RST = 1'b0;
        @(negedge FAB_CLK);
        chk("reset.busy", int'(BUSY), 0);
        chk("reset.done", int'(DONE), 0);
        chk("reset.err", int'(ERR), 0);
        chk("reset.strobes", int'({MOVE, DIR, LOAD, CLEAR}), 0);
        read_res(1, v); chk("reset.result1", v, 0);

        foreach (vecs[i]) begin
            mask[0] = vecs[i].m0;
            mask[1] = vecs[i].m1;
            oor_en[0] = vecs[i].oen0;
            oor_tap[0] = vecs[i].otap0;
            oor_en[1] = 0;
            run_train(1'b0);
            check_run($sformatf("vec%0d", i), vecs[i].r0, vecs[i].r1, vecs[i].err,
                      vecs[i].up0, vecs[i].dn0, vecs[i].ld0, vecs[i].up1, vecs[i].dn1, 1);
        end

        for (int t = 0; t < 10; t++) begin
            for (int b = 0; b < NB; b++) begin
                mask[b] = '0;
                if ($urandom_range(0, 4) != 0) begin
                    for (int w = 0; w < int'($urandom_range(1, 3)); w++) begin
                        int s, l;
                        s = $urandom_range(0, 15);
                        l = $urandom_range(1, 8);
                        for (int k = s; k < s + l && k <= MT; k++) mask[b][k] = 1'b1;
                    end
                end
                oor_en[b]  = ($urandom_range(0, 3) == 0);
                oor_tap[b] = $urandom_range(0, 15);
                ref_bit(mask[b], oor_en[b], oor_tap[b], up[b], dn[b], ld[b], res[b], er[b]);
            end
            run_train(1'b0);
            check_run($sformatf("rand%0d", t), res[0], res[1], int'({er[1], er[0]}),
                      up[0], dn[0], ld[0], up[1], dn[1], ld[1]);
        end

        // Reset in the middle of bit 0's sweep, with START held alongside it.
        mask[0] = 16'h07F0; mask[1] = 16'h3F0F;
        oor_en[0] = 0; oor_en[1] = 0;
        @(posedge FAB_CLK); #1 START = 1'b1;
        @(posedge FAB_CLK); #1 START = 1'b0;
        got = 0;
        for (int c = 0; c < 500 && !got; c++) begin
            @(posedge FAB_CLK); #1;
            if (mtap[0] == 6) got = 1;
        end
        chk("midreset.reached_tap6", int'(got), 1);
        SYNC_RST = 1'b1;
        START = 1'b1;
        @(posedge FAB_CLK); #1;
        SYNC_RST = 1'b0;
        START = 1'b0;
        @(negedge FAB_CLK);
        chk("midreset.busy", int'(BUSY), 0);
        chk("midreset.done", int'(DONE), 0);
        chk("midreset.err", int'(ERR), 0);
        chk("midreset.strobes", int'({MOVE, DIR, LOAD, CLEAR}), 0);
        read_res(0, v); chk("midreset.result0", v, 0);
        read_res(1, v); chk("midreset.result1", v, 0);
        @(negedge FAB_CLK);
        chk("midreset.start_ignored", int'(BUSY), 0);
        run_train(1'b0);
        check_run("after_reset", 7, 10, 0, 15, 8, 1, 15, 5, 1);

        run_train(1'b1);
        check_run("start_while_busy", 7, 10, 0, 15, 8, 1, 15, 5, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
